// File: rtl/vend_multi.sv
// Multi-item coin vending controller: per-item prices and stock, credit ceiling,
// cancel/refund and sold-out flags. Define VEND_AUDIT_EN to add the sales_total counter.
module vend_multi #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned COIN_W     = 3,
  parameter int unsigned CREDIT_W   = 5,
  parameter int unsigned MAX_CREDIT = 31,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {5'd12, 5'd9, 5'd7, 5'd5},
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COIN_W-1:0]    in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 buy,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 out,
  output logic [SEL_W-1:0]     item,
  output logic [CREDIT_W-1:0]  ch,
  output logic                 ch_valid,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 deny,
  output logic                 coin_rej,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] sold_out
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0]          sales_total
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  state_t               r_state;
  logic [CREDIT_W-1:0]  r_credit;
  logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];
  logic                 r_out;
  logic [SEL_W-1:0]     r_item;
  logic [CREDIT_W-1:0]  r_ch;
  logic                 r_ch_valid;
  logic                 r_deny;
  logic                 r_coin_rej;
`ifdef VEND_AUDIT_EN
  logic [15:0]          r_sales;
`endif

  logic                 w_coin;
  logic [CREDIT_W:0]    w_sum;
  logic                 w_sel_ok;
  logic [CREDIT_W-1:0]  w_price;
  logic [STOCK_W-1:0]   w_stock_sel;
  logic                 w_buy_ok;

  // Item lookup by matching sel against each index keeps out-of-range selects harmless.
  always_comb begin
    w_coin      = (in != '0);
    w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(in);
    w_sel_ok    = 1'b0;
    w_price     = '0;
    w_stock_sel = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        w_sel_ok    = 1'b1;
        w_price     = PRICES[i*CREDIT_W +: CREDIT_W];
        w_stock_sel = r_stock[i];
      end
    end
    w_buy_ok = w_sel_ok && (w_stock_sel != '0) && (r_credit >= w_price);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_out      <= 1'b0;
      r_item     <= '0;
      r_ch       <= '0;
      r_ch_valid <= 1'b0;
      r_deny     <= 1'b0;
      r_coin_rej <= 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
`ifdef VEND_AUDIT_EN
      r_sales    <= '0;
`endif
    end else begin
      r_out      <= 1'b0;
      r_item     <= '0;
      r_ch       <= '0;
      r_ch_valid <= 1'b0;
      r_deny     <= 1'b0;
      r_coin_rej <= 1'b0;
      case (r_state)
        S_VEND: begin
          r_state    <= S_CHANGE;
          r_ch       <= r_credit;
          r_ch_valid <= 1'b1;
          r_credit   <= '0;
          r_coin_rej <= w_coin;
        end
        S_CHANGE: begin
          r_state    <= S_IDLE;
          r_coin_rej <= w_coin;
        end
        default: begin
          if (cancel && (r_credit != '0)) begin
            r_state    <= S_CHANGE;
            r_ch       <= r_credit;
            r_ch_valid <= 1'b1;
            r_credit   <= '0;
            r_coin_rej <= w_coin;
          end else if (buy) begin
            r_coin_rej <= w_coin;
            if (w_buy_ok) begin
              r_state  <= S_VEND;
              r_out    <= 1'b1;
              r_item   <= sel;
              r_credit <= r_credit - w_price;
              for (int unsigned i = 0; i < NUM_ITEMS; i++)
                if (sel == SEL_W'(i)) r_stock[i] <= r_stock[i] - 1'b1;
`ifdef VEND_AUDIT_EN
              r_sales  <= r_sales + 16'(w_price);
`endif
            end else begin
              r_deny <= 1'b1;
            end
          end else if (w_coin) begin
            // A zero-credit cancel is ignored but still makes a coin in that cycle unacceptable.
            if (!cancel && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT))) begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_state  <= S_COLLECT;
            end else begin
              r_coin_rej <= 1'b1;
            end
          end else if (restock && (r_state == S_IDLE)) begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) sold_out[i] = (r_stock[i] == '0);
  end

  assign out      = r_out;
  assign item     = r_item;
  assign ch       = r_ch;
  assign ch_valid = r_ch_valid;
  assign credit   = r_credit;
  assign deny     = r_deny;
  assign coin_rej = r_coin_rej;
  assign busy     = (r_state == S_VEND) || (r_state == S_CHANGE);
`ifdef VEND_AUDIT_EN
  assign sales_total = r_sales;
`endif

endmodule

// File: tb/tb_vend_multi.sv
// Self-checking bench for vend_multi: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_vend_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in = '0;
  logic [1:0] sel = '0;
  logic       buy = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic       out, ch_valid, deny, coin_rej, busy;
  logic [1:0] item;
  logic [4:0] ch, credit;
  logic [3:0] sold_out;
`ifdef VEND_AUDIT_EN
  logic [15:0] sales_total;
`endif

  vend_multi dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .buy(buy), .cancel(cancel),
    .restock(restock), .out(out), .item(item), .ch(ch), .ch_valid(ch_valid),
    .credit(credit), .deny(deny), .coin_rej(coin_rej), .busy(busy), .sold_out(sold_out)
`ifdef VEND_AUDIT_EN
    , .sales_total(sales_total)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: credit/stock as integers, busy time as a countdown.
  int  PR [4] = '{5, 7, 9, 12};
  int  m_credit, m_busy_left, m_sales;
  int  m_stock [4];
  bit  m_refund_due;
  bit  m_valid = 1'b0;
  int  e_out, e_item, e_ch, e_chv, e_deny, e_rej;

  always @(posedge clk) begin
    e_out = 0; e_item = 0; e_ch = 0; e_chv = 0; e_deny = 0; e_rej = 0;
    if (rst) begin
      m_credit = 0; m_busy_left = 0; m_refund_due = 0; m_sales = 0; m_valid = 1;
      for (int i = 0; i < 4; i++) m_stock[i] = 2;
    end else if (m_busy_left > 0) begin
      e_rej = (in != 0);
      if (m_refund_due) begin
        e_ch = m_credit; e_chv = 1; m_credit = 0; m_refund_due = 0;
      end
      m_busy_left--;
    end else if (cancel && m_credit > 0) begin
      e_ch = m_credit; e_chv = 1; m_credit = 0; m_busy_left = 1;
      e_rej = (in != 0);
    end else if (buy) begin
      e_rej = (in != 0);
      if (m_stock[sel] > 0 && m_credit >= PR[sel]) begin
        e_out = 1; e_item = int'(sel);
        m_stock[sel]--;
        m_credit -= PR[sel];
        m_sales = (m_sales + PR[sel]) % 65536;
        m_busy_left = 2; m_refund_due = 1;
      end else begin
        e_deny = 1;
      end
    end else if (in != 0) begin
      if (cancel || m_credit + int'(in) > 31) e_rej = 1;
      else m_credit += int'(in);
    end else if (restock && m_credit == 0) begin
      for (int i = 0; i < 4; i++) m_stock[i] = 2;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int so;
      so = 0;
      for (int i = 0; i < 4; i++) if (m_stock[i] == 0) so |= (1 << i);
      chk("out", int'(out), e_out);
      if (e_out != 0) chk("item", int'(item), e_item);
      chk("ch_valid", int'(ch_valid), e_chv);
      if (e_chv != 0) chk("ch", int'(ch), e_ch);
      chk("deny", int'(deny), e_deny);
      chk("coin_rej", int'(coin_rej), e_rej);
      chk("credit", int'(credit), m_credit);
      chk("busy", int'(busy), int'(m_busy_left > 0));
      chk("sold_out", int'(sold_out), so);
`ifdef VEND_AUDIT_EN
      chk("sales_total", int'(sales_total), m_sales);
`endif
    end
  end

  task automatic step(input int c, input int s, input bit b, input bit k, input bit r);
    @(negedge clk);
    rst = 1'b0; in = 3'(c); sel = 2'(s); buy = b; cancel = k; restock = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in = '0; sel = '0; buy = 0; cancel = 0; restock = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_credit", int'(credit), 0);
    chk("rst_sold_out", int'(sold_out), 0);
    chk("rst_out", int'(out), 0);

    // Coins 1,2,5 then buy item0 (price 5): change 3.
    step(1, 0, 0, 0, 0); step(2, 0, 0, 0, 0); step(5, 0, 0, 0, 0);
    chk("t1_credit8", int'(credit), 8);
    step(0, 0, 1, 0, 0);
    chk("t1_out", int'(out), 1);
    chk("t1_item", int'(item), 0);
    step(0, 0, 0, 0, 0);
    chk("t1_chv", int'(ch_valid), 1);
    chk("t1_ch3", int'(ch), 3);
    chk("t1_credit0", int'(credit), 0);
    step(0, 0, 0, 0, 0);

    // Second item0 vend empties it; third attempt is denied.
    step(5, 0, 0, 0, 0); step(0, 0, 1, 0, 0);
    chk("t2_sold_out0", int'(sold_out), 1);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(5, 0, 0, 0, 0); step(0, 0, 1, 0, 0);
    chk("t2_deny", int'(deny), 1);
    chk("t2_credit5", int'(credit), 5);
    step(0, 0, 0, 1, 0);
    chk("t2_refund5", int'(ch), 5);
    step(0, 0, 0, 0, 0);

    // Restock in IDLE, then insufficient credit for item1 and a cancel.
    step(0, 0, 0, 0, 1);
    chk("t3_restocked", int'(sold_out), 0);
    step(2, 0, 0, 0, 0); step(2, 0, 0, 0, 0); step(0, 1, 1, 0, 0);
    chk("t3_deny", int'(deny), 1);
    chk("t3_credit4", int'(credit), 4);
    step(0, 0, 0, 1, 0);
    chk("t3_chv", int'(ch_valid), 1);
    chk("t3_ch4", int'(ch), 4);
    chk("t3_no_out", int'(out), 0);
    chk("t3_credit0", int'(credit), 0);
    step(0, 0, 0, 0, 0);

    // Credit ceiling.
    repeat (6) step(5, 0, 0, 0, 0);
    chk("t4_credit30", int'(credit), 30);
    step(2, 0, 0, 0, 0);
    chk("t4_rej", int'(coin_rej), 1);
    chk("t4_hold30", int'(credit), 30);
    step(1, 0, 0, 0, 0);
    chk("t4_credit31", int'(credit), 31);
    step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);

    // Exact price with coin alongside buy, then coin during VEND.
    step(5, 0, 0, 0, 0); step(5, 0, 0, 0, 0); step(2, 0, 0, 0, 0);
    step(3, 3, 1, 0, 0);
    chk("t5_out", int'(out), 1);
    chk("t5_item3", int'(item), 3);
    chk("t5_rej_buy", int'(coin_rej), 1);
    chk("t5_credit0", int'(credit), 0);
    step(1, 0, 0, 0, 0);
    chk("t5_rej_busy", int'(coin_rej), 1);
    chk("t5_chv", int'(ch_valid), 1);
    chk("t5_ch0", int'(ch), 0);
    step(0, 0, 0, 0, 0);

    // Reset landing in the VEND cycle.
    step(5, 0, 0, 0, 0); step(0, 0, 1, 0, 0);
`ifdef VEND_AUDIT_EN
    chk("t6_sales", int'(sales_total), 27);
`endif
    do_reset();
    chk("t6_out", int'(out), 0);
    chk("t6_chv", int'(ch_valid), 0);
    chk("t6_credit", int'(credit), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_sold_out", int'(sold_out), 0);
`ifdef VEND_AUDIT_EN
    chk("t6_sales0", int'(sales_total), 0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) == 0);
      in      = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      sel     = 2'($urandom_range(0, 3));
      buy     = ($urandom_range(0, 4) == 0);
      cancel  = ($urandom_range(0, 19) == 0);
      restock = ($urandom_range(0, 14) == 0);
    end
    @(negedge clk);
    rst = 0; in = '0; buy = 0; cancel = 0; restock = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
